cb_rr_arbiter: RTL and testbench
================================

CB_RR_ARBITER -- requirements
Module: cb_rr_arbiter

Interface
REQ-001 Parameter NUM_MST, default 2, number of core-bus masters (2..8).
REQ-002 Parameter ADDR_W, default 32, request address width.
REQ-003 Parameter DATA_W, default 32, data width; strobe width DATA_W/8.
REQ-004 Parameter MAX_OUT, default 4, max outstanding requests (power of 2, 2..16); TW = clog2(NUM_MST).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 arst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-007 m_req_valid_i / m_req_ready_o  in/out  NUM_MST  per-master request handshake.
REQ-008 m_req_addr_i  in  NUM_MST*ADDR_W  per-master address, master i at slice i.
REQ-009 m_req_we_i  in  NUM_MST; m_req_wdata_i  in  NUM_MST*DATA_W; m_req_wstrb_i  in  NUM_MST*DATA_W/8.
REQ-010 m_resp_valid_o / m_resp_ready_i  out/in  NUM_MST  per-master response handshake.
REQ-011 m_resp_rdata_o  out  DATA_W, m_resp_err_o  out  1  broadcast response payload.
REQ-012 s_req_valid_o, s_req_ready_i, s_req_addr_o (ADDR_W), s_req_we_o, s_req_wdata_o (DATA_W), s_req_wstrb_o (DATA_W/8)  slave request channel.
REQ-013 s_resp_valid_i, s_resp_ready_o, s_resp_rdata_i (DATA_W), s_resp_err_i  slave response channel.
REQ-014 busy_o  out  1  outstanding count nonzero; unexp_resp_o  out  1  sticky unexpected-response flag.

Function
REQ-015 Handshake on any channel SHALL occur in a cycle where valid and ready are both 1; payload qualified only by valid.
REQ-016 Grant SHALL be round-robin: search starts at rr_ptr, wraps NUM_MST-1 -> 0; first requesting master wins.
REQ-017 On request handshake rr_ptr SHALL become (granted index + 1) mod NUM_MST; otherwise unchanged.
REQ-018 Grant SHALL be locked while s_req_valid_o=1 and s_req_ready_i=0; no switching until handshake.
REQ-019 s_req_* SHALL be combinational mux of granted master; zero-cycle request latency.
REQ-020 s_req_valid_o SHALL be 0 when tag FIFO full (count == MAX_OUT); m_req_ready_o[i] = granted(i) & s_req_ready_i & !full.
REQ-021 Tag FIFO (depth MAX_OUT, TW-bit entries) SHALL push granted index on request handshake, pop on response handshake; in-order responses.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, pointers both advance, wrap mod MAX_OUT.
REQ-023 When count > 0: m_resp_valid_o[head] = s_resp_valid_i, others 0; s_resp_ready_o = m_resp_ready_i[head]; rdata/err pass through combinationally.
REQ-024 When count == 0: s_resp_ready_o SHALL be 1, all m_resp_valid_o 0, any s_resp_valid_i consumed and unexp_resp_o set to 1 until reset.
REQ-025 Count SHALL never exceed MAX_OUT nor underflow below 0.
REQ-026 busy_o SHALL be registered-equivalent (count != 0), updating cycle after the handshake that changes count.

Reset
REQ-027 While arst=0: count=0, FIFO pointers=0, rr_ptr=0, unexp_resp_o=0, busy_o=0, all m_resp_valid_o=0, grant lock cleared.
REQ-028 Reset mid-transaction SHALL discard all outstanding tags; later slave responses are treated per REQ-024.
REQ-029 Reset deassertion SHALL take effect on next rising clk; first arbitration starts at master 0.

Verification
REQ-030 NUM_MST=2, both valid every cycle, s_req_ready_i=1, immediate responses -> grants alternate 0,1,0,1; each master's response routed only to it.
REQ-031 MAX_OUT=4, s_resp_valid_i held 0, master 0 issues 6 requests -> 4 handshakes, then s_req_valid_o=0, busy_o=1; one response frees exactly one slot.
REQ-032 Master 1 valid, s_req_ready_i=0 for 3 cycles, master 0 asserts in cycle 2 -> grant stays on 1, handshake with addr of master 1 on cycle 4, rr_ptr -> 0.
REQ-033 count=2 and same-cycle request + response handshakes -> count stays 2, tag order preserved, FIFO wraps correctly after 8 such cycles.
REQ-034 After reset, s_resp_valid_i=1 with no requests -> s_resp_ready_o=1, no m_resp_valid_o, unexp_resp_o=1 next cycle and stays until arst=0.

Source files
------------

// File: rtl/cb_rr_arbiter.sv
// Round-robin core-bus arbiter: NUM_MST masters share one slave port; a tag FIFO
// remembers who issued each outstanding request so in-order responses route back.
module cb_rr_arbiter #(
   parameter int NUM_MST = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 4
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic [NUM_MST-1:0]          m_req_valid_i,
   output logic [NUM_MST-1:0]          m_req_ready_o,
   input  logic [NUM_MST*ADDR_W-1:0]   m_req_addr_i,
   input  logic [NUM_MST-1:0]          m_req_we_i,
   input  logic [NUM_MST*DATA_W-1:0]   m_req_wdata_i,
   input  logic [NUM_MST*DATA_W/8-1:0] m_req_wstrb_i,
   output logic [NUM_MST-1:0]          m_resp_valid_o,
   input  logic [NUM_MST-1:0]          m_resp_ready_i,
   output logic [DATA_W-1:0]           m_resp_rdata_o,
   output logic                        m_resp_err_o,
   output logic                        s_req_valid_o,
   input  logic                        s_req_ready_i,
   output logic [ADDR_W-1:0]           s_req_addr_o,
   output logic                        s_req_we_o,
   output logic [DATA_W-1:0]           s_req_wdata_o,
   output logic [DATA_W/8-1:0]         s_req_wstrb_o,
   input  logic                        s_resp_valid_i,
   output logic                        s_resp_ready_o,
   input  logic [DATA_W-1:0]           s_resp_rdata_i,
   input  logic                        s_resp_err_i,
   output logic                        busy_o,
   output logic                        unexp_resp_o
);

   localparam int SW = DATA_W / 8;
   localparam int TW = $clog2(NUM_MST);
   localparam int PW = $clog2(MAX_OUT);
   localparam int CW = PW + 1;

   logic [TW-1:0] rr_ptr;
   logic [TW-1:0] lock_idx;
   logic          locked;
   logic [TW-1:0] grant_idx;
   logic          have_grant;

   logic [TW-1:0] tag_mem [MAX_OUT];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] head;
   logic          full;
   logic          empty;
   logic          req_hs;
   logic          resp_hs;

   // Index arithmetic modulo NUM_MST, which need not be a power of two.
   function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_MST) s = s - NUM_MST;
      return s[TW-1:0];
   endfunction

   assign full  = (count == CW'(MAX_OUT));
   assign empty = (count == '0);
   assign head  = tag_mem[rd_ptr];

   // NOTE: every always_comb output gets a default first, so no path leaves a latch.
   always_comb begin
      grant_idx  = rr_ptr;
      have_grant = 1'b0;
      if (locked) begin
         grant_idx  = lock_idx;
         have_grant = m_req_valid_i[lock_idx];
      end else begin
         // Walk backwards so the candidate closest to rr_ptr is assigned last and wins.
         for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (m_req_valid_i[wrap_add(rr_ptr, k)]) begin
               grant_idx  = wrap_add(rr_ptr, k);
               have_grant = 1'b1;
            end
         end
      end
   end

   always_comb begin
      s_req_valid_o = have_grant & ~full;
      s_req_addr_o  = m_req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
      s_req_we_o    = m_req_we_i[grant_idx];
      s_req_wdata_o = m_req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
      s_req_wstrb_o = m_req_wstrb_i[int'(grant_idx)*SW +: SW];
      for (int i = 0; i < NUM_MST; i++) begin
         m_req_ready_o[i] = have_grant & (grant_idx == TW'(i)) & s_req_ready_i & ~full;
      end
   end

   assign req_hs = s_req_valid_o & s_req_ready_i;

   always_comb begin
      m_resp_valid_o = '0;
      s_resp_ready_o = 1'b1;
      if (!empty) begin
         m_resp_valid_o[head] = s_resp_valid_i;
         s_resp_ready_o       = m_resp_ready_i[head];
      end
   end

   assign resp_hs        = s_resp_valid_i & s_resp_ready_o & ~empty;
   assign m_resp_rdata_o = s_resp_rdata_i;
   assign m_resp_err_o   = s_resp_err_i;
   assign busy_o         = ~empty;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         rr_ptr       <= '0;
         locked       <= 1'b0;
         lock_idx     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         unexp_resp_o <= 1'b0;
      end else begin
         // A stalled request keeps its grant until the slave accepts it.
         locked   <= s_req_valid_o & ~s_req_ready_i;
         lock_idx <= grant_idx;
         if (req_hs) begin
            rr_ptr <= wrap_add(grant_idx, 1);
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (resp_hs) rd_ptr <= rd_ptr + 1'b1;
         case ({req_hs, resp_hs})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (s_resp_valid_i && empty) unexp_resp_o <= 1'b1;
      end
   end

   // NOTE: tag storage is not reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (req_hs) tag_mem[wr_ptr] <= grant_idx;
   end

endmodule

// File: tb/tb_cb_rr_arbiter.sv
// Randomized scoreboard bench for cb_rr_arbiter: a transaction-level model predicts
// every request/response handshake; a separate monitor pops and compares them.
module tb_cb_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int MO = 4;

   logic              clk = 1'b0;
   logic              arst;
   logic [N-1:0]      m_req_valid_i;
   logic [N-1:0]      m_req_ready_o;
   logic [N*AW-1:0]   m_req_addr_i;
   logic [N-1:0]      m_req_we_i;
   logic [N*DW-1:0]   m_req_wdata_i;
   logic [N*SW-1:0]   m_req_wstrb_i;
   logic [N-1:0]      m_resp_valid_o;
   logic [N-1:0]      m_resp_ready_i;
   logic [DW-1:0]     m_resp_rdata_o;
   logic              m_resp_err_o;
   logic              s_req_valid_o;
   logic              s_req_ready_i;
   logic [AW-1:0]     s_req_addr_o;
   logic              s_req_we_o;
   logic [DW-1:0]     s_req_wdata_o;
   logic [SW-1:0]     s_req_wstrb_o;
   logic              s_resp_valid_i;
   logic              s_resp_ready_o;
   logic [DW-1:0]     s_resp_rdata_i;
   logic              s_resp_err_i;
   logic              busy_o;
   logic              unexp_resp_o;

   always #5 clk = ~clk;

   cb_rr_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
      .clk(clk), .arst(arst),
      .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
      .m_req_addr_i(m_req_addr_i), .m_req_we_i(m_req_we_i),
      .m_req_wdata_i(m_req_wdata_i), .m_req_wstrb_i(m_req_wstrb_i),
      .m_resp_valid_o(m_resp_valid_o), .m_resp_ready_i(m_resp_ready_i),
      .m_resp_rdata_o(m_resp_rdata_o), .m_resp_err_o(m_resp_err_o),
      .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
      .s_req_addr_o(s_req_addr_o), .s_req_we_o(s_req_we_o),
      .s_req_wdata_o(s_req_wdata_o), .s_req_wstrb_o(s_req_wstrb_o),
      .s_resp_valid_i(s_resp_valid_i), .s_resp_ready_o(s_resp_ready_o),
      .s_resp_rdata_i(s_resp_rdata_i), .s_resp_err_i(s_resp_err_i),
      .busy_o(busy_o), .unexp_resp_o(unexp_resp_o)
   );

   typedef struct {
      int            idx;
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
   } req_t;

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   req_t  exp_req_q[$];
   resp_t exp_resp_q[$];

   // Master-side stimulus: each master holds its payload until accepted.
   logic          pending [N];
   logic [AW-1:0] p_addr  [N];
   logic          p_we    [N];
   logic [DW-1:0] p_wdata [N];
   logic [SW-1:0] p_wstrb [N];

   // Reference model state.
   int   rr;
   int   lock;
   int   tags[$];
   bit   unexp;
   bit   exp_svalid;
   bit   exp_busy;
   bit   exp_unexp;
   bit   exp_srr;
   bit   exp_empty;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_buses();
      for (int i = 0; i < N; i++) begin
         m_req_valid_i[i]              = pending[i];
         m_req_addr_i[i*AW +: AW]      = p_addr[i];
         m_req_we_i[i]                 = p_we[i];
         m_req_wdata_i[i*DW +: DW]     = p_wdata[i];
         m_req_wstrb_i[i*SW +: SW]     = p_wstrb[i];
      end
   endtask

   task automatic model_reset();
      rr = 0;
      lock = -1;
      tags.delete();
      unexp = 1'b0;
      exp_svalid = 1'b0;
      exp_busy = 1'b0;
      exp_unexp = 1'b0;
      exp_srr = 1'b1;
      exp_empty = 1'b1;
   endtask

   // One clock of the arbitration rules applied to the inputs now on the pins.
   task automatic model_step();
      int  n;
      int  g;
      int  head;
      bit  found;
      bit  req_hs;
      bit  resp_hs;
      n = tags.size();
      g = -1;
      found = 1'b0;
      if (lock >= 0) begin
         if (pending[lock]) g = lock;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!found && pending[(rr + k) % N]) begin
               g = (rr + k) % N;
               found = 1'b1;
            end
         end
      end
      exp_svalid = (g >= 0) && (n < MO);
      req_hs     = exp_svalid && s_req_ready_i;
      exp_busy   = (n != 0);
      exp_unexp  = unexp;
      exp_empty  = (n == 0);
      resp_hs    = 1'b0;
      if (n > 0) begin
         head    = tags[0];
         exp_srr = m_resp_ready_i[head];
         resp_hs = s_resp_valid_i && m_resp_ready_i[head];
      end else begin
         head    = 0;
         exp_srr = 1'b1;
         if (s_resp_valid_i) unexp = 1'b1;
      end
      if (resp_hs) begin
         exp_resp_q.push_back('{head, s_resp_rdata_i, s_resp_err_i});
         void'(tags.pop_front());
      end
      if (req_hs) begin
         exp_req_q.push_back('{g, p_addr[g], p_we[g], p_wdata[g], p_wstrb[g]});
         tags.push_back(g);
         rr = (g + 1) % N;
         pending[g] = 1'b0;
      end
      lock = (exp_svalid && !s_req_ready_i) ? g : -1;
   endtask

   task automatic cycle(input int p_req, input int p_sr, input int p_rv, input int p_rr);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!pending[i] && ($urandom_range(99) < p_req)) begin
            pending[i] = 1'b1;
            p_addr[i]  = AW'($urandom);
            p_we[i]    = 1'($urandom);
            p_wdata[i] = $urandom;
            p_wstrb[i] = SW'($urandom);
         end
         m_resp_ready_i[i] = ($urandom_range(99) < p_rr);
      end
      s_req_ready_i  = ($urandom_range(99) < p_sr);
      s_resp_valid_i = ($urandom_range(99) < p_rv);
      s_resp_rdata_i = $urandom;
      s_resp_err_i   = 1'($urandom);
      drive_buses();
      #1;
      model_step();
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      arst = 1'b0;
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      s_req_ready_i  = 1'b0;
      s_resp_valid_i = 1'b0;
      m_resp_ready_i = '0;
      drive_buses();
      model_reset();
      repeat (n) @(negedge clk);
      arst = 1'b1;
   endtask

   // Monitor: compares DUT pins against the model's predictions each cycle.
   initial begin
      req_t  r;
      resp_t p;
      logic [N-1:0] rm;
      forever begin
         @(negedge clk);
         #2;
         if (!arst) begin
            check("rst_busy", busy_o, 0);
            check("rst_unexp", unexp_resp_o, 0);
            check("rst_resp_valid", m_resp_valid_o, 0);
         end else begin
            check("s_req_valid", s_req_valid_o, exp_svalid);
            check("busy", busy_o, exp_busy);
            check("unexp_resp", unexp_resp_o, exp_unexp);
            check("s_resp_ready", s_resp_ready_o, exp_srr);
            if (s_req_valid_o && s_req_ready_i) begin
               if (exp_req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL req_extra: got handshake addr %0h expected none", s_req_addr_o);
               end else begin
                  r = exp_req_q.pop_front();
                  check("req_grant", m_req_ready_o & m_req_valid_i, 64'(1) << r.idx);
                  check("req_addr", s_req_addr_o, r.addr);
                  check("req_we", s_req_we_o, r.we);
                  check("req_wdata", s_req_wdata_o, r.wdata);
                  check("req_wstrb", s_req_wstrb_o, r.wstrb);
               end
            end else begin
               check("req_ready_idle", m_req_ready_o & m_req_valid_i, 0);
               if (exp_req_q.size() != 0) begin
                  r = exp_req_q.pop_front();
                  checks++;
                  errors++;
                  $display("FAIL req_missing: got no handshake expected master %0d", r.idx);
               end
            end
            rm = m_resp_valid_o & m_resp_ready_i;
            if (rm != '0) begin
               if (exp_resp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL resp_extra: got mask %0h expected none", rm);
               end else begin
                  p = exp_resp_q.pop_front();
                  check("resp_route", rm, 64'(1) << p.idx);
                  check("resp_rdata", m_resp_rdata_o, p.rdata);
                  check("resp_err", m_resp_err_o, p.err);
               end
            end else if (exp_resp_q.size() != 0) begin
               p = exp_resp_q.pop_front();
               checks++;
               errors++;
               $display("FAIL resp_missing: got no handshake expected master %0d", p.idx);
            end
            if (exp_empty) check("resp_valid_idle", m_resp_valid_o, 0);
         end
      end
   end

   initial begin
      arst           = 1'b0;
      s_req_ready_i  = 1'b0;
      s_resp_valid_i = 1'b0;
      s_resp_rdata_i = '0;
      s_resp_err_i   = 1'b0;
      m_resp_ready_i = '0;
      for (int i = 0; i < N; i++) begin
         pending[i] = 1'b0;
         p_addr[i]  = '0;
         p_we[i]    = 1'b0;
         p_wdata[i] = '0;
         p_wstrb[i] = '0;
      end
      drive_buses();
      model_reset();

      apply_reset(3);
      // Stray responses with nothing outstanding.
      repeat (4) cycle(0, 100, 100, 100);
      apply_reset(2);
      // Full throughput: simultaneous push and pop, rotating grants.
      repeat (40) cycle(100, 100, 100, 100);
      // Fill the tag FIFO to its limit, then let it drain one slot at a time.
      repeat (12) cycle(100, 100, 0, 100);
      repeat (10) cycle(100, 100, 30, 100);
      // Reset with tags outstanding; later responses count as unexpected.
      repeat (12) cycle(100, 100, 0, 100);
      apply_reset(2);
      repeat (6) cycle(0, 100, 100, 100);
      apply_reset(1);
      // Mixed random traffic, then heavy slave back-pressure to exercise grant locking.
      repeat (1500) cycle(60, 70, 50, 80);
      repeat (500) cycle(90, 25, 60, 60);
      repeat (300) cycle(40, 90, 90, 40);
      // Drain everything still outstanding.
      repeat (40) cycle(0, 100, 100, 100);

      @(negedge clk);
      #5;
      check("req_queue_drained", 64'(exp_req_q.size()), 0);
      check("resp_queue_drained", 64'(exp_resp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
